// File: rtl/uart8_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart8_if : on-chip side and serial pins of the uart8 rx/tx engines          |
// | Rev 1.0  : initial release                                                  |
// +----------------------------------------------------------------------------+
interface uart8_if;
  logic       rxEn;
  logic       rx;
  logic       rxBusy;
  logic       rxDone;
  logic       rxErr;
  logic [7:0] out;
  logic       txEn;
  logic       txStart;
  logic [7:0] in;
  logic       txBusy;
  logic       txDone;
  logic       tx;

  modport master (
    output rxEn, rx, txEn, txStart, in,
    input  rxBusy, rxDone, rxErr, out, txBusy, txDone, tx
  );

  modport slave (
    input  rxEn, rx, txEn, txStart, in,
    output rxBusy, rxDone, rxErr, out, txBusy, txDone, tx
  );
endinterface
`default_nettype wire

// File: rtl/uart8.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart8 : full-duplex 8N1 UART, 16x oversampled receiver, 1x-tick transmitter |
// | Rev 1.0  : initial release                                                  |
// +----------------------------------------------------------------------------+
module uart8 #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600
) (
  input wire     clk,
  input wire     reset,
  uart8_if.slave bus
);

  localparam int c_RX_DIV = CLOCK_RATE / (16 * BAUD_RATE);
  localparam int c_TX_DIV = CLOCK_RATE / BAUD_RATE;
  localparam int c_RXD_W  = (c_RX_DIV > 1) ? $clog2(c_RX_DIV) : 1;
  localparam int c_TXD_W  = (c_TX_DIV > 1) ? $clog2(c_TX_DIV) : 1;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_ERROR = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // ---------------- receive front end ----------------
  logic               rx_meta_q, rx_sync_q;
  logic [c_RXD_W-1:0] rx_div_q, rx_div_d;
  logic               w_rx_tick;

  assign w_rx_tick = (rx_div_q == c_RXD_W'(c_RX_DIV - 1));
  assign rx_div_d  = w_rx_tick ? '0 : rx_div_q + c_RXD_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_div_q  <= '0;
    end else begin
      rx_meta_q <= bus.rx;
      rx_sync_q <= rx_meta_q;
      rx_div_q  <= rx_div_d;
    end
  end

  // ---------------- receive engine ----------------
  rx_state_t  rx_state_q, rx_state_d;
  logic [3:0] rx_tcnt_q, rx_tcnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_out_q, rx_out_d;
  logic       rx_busy_q, rx_busy_d;
  logic       rx_done_q, rx_done_d;
  logic       rx_err_q, rx_err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_tcnt_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_out_q   <= '0;
      rx_busy_q  <= 1'b0;
      rx_done_q  <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_out_q   <= rx_out_d;
      rx_busy_q  <= rx_busy_d;
      rx_done_q  <= rx_done_d;
      rx_err_q   <= rx_err_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_out_d   = rx_out_q;
    rx_busy_d  = rx_busy_q;
    rx_done_d  = 1'b0;
    rx_err_d   = rx_err_q;

    if (!bus.rxEn) begin
      rx_state_d = RX_IDLE;
      rx_tcnt_d  = '0;
      rx_bit_d   = '0;
      rx_busy_d  = 1'b0;
      rx_err_d   = 1'b0;
    end else begin
      unique case (rx_state_q)
        RX_IDLE: begin
          if (!rx_sync_q) begin
            rx_state_d = RX_START;
            rx_tcnt_d  = '0;
            rx_bit_d   = '0;
            rx_busy_d  = 1'b1;
            rx_err_d   = 1'b0;
          end
        end
        RX_START: begin
          // Eighth tick lands mid start bit; a high line here was only a glitch.
          if (w_rx_tick) begin
            if (rx_tcnt_q == 4'd7) begin
              rx_tcnt_d = '0;
              if (rx_sync_q) begin
                rx_state_d = RX_IDLE;
                rx_busy_d  = 1'b0;
              end else begin
                rx_state_d = RX_DATA;
              end
            end else begin
              rx_tcnt_d = rx_tcnt_q + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (w_rx_tick) begin
            rx_tcnt_d = rx_tcnt_q + 4'd1;
            if (rx_tcnt_q == 4'd15) begin
              rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
              rx_bit_d   = rx_bit_q + 3'd1;
              if (rx_bit_q == 3'd7) begin
                rx_state_d = RX_STOP;
              end
            end
          end
        end
        RX_STOP: begin
          if (w_rx_tick) begin
            rx_tcnt_d = rx_tcnt_q + 4'd1;
            if (rx_tcnt_q == 4'd15) begin
              rx_busy_d = 1'b0;
              if (rx_sync_q) begin
                rx_out_d   = rx_shift_q;
                rx_done_d  = 1'b1;
                rx_state_d = RX_IDLE;
              end else begin
                rx_err_d   = 1'b1;
                rx_state_d = RX_ERROR;
              end
            end
          end
        end
        RX_ERROR: begin
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
          end
        end
        default: begin
          rx_state_d = RX_IDLE;
          rx_busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign bus.rxBusy = rx_busy_q;
  assign bus.rxDone = rx_done_q;
  assign bus.rxErr  = rx_err_q;
  assign bus.out    = rx_out_q;

  // ---------------- transmit engine ----------------
  tx_state_t          tx_state_q, tx_state_d;
  logic [c_TXD_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]         tx_bit_q, tx_bit_d;
  logic [7:0]         tx_shift_q, tx_shift_d;
  logic               tx_q, tx_d;
  logic               tx_busy_q, tx_busy_d;
  logic               tx_done_q, tx_done_d;
  logic               w_tx_last;

  assign w_tx_last = (tx_cnt_q == c_TXD_W'(c_TX_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_busy_d  = tx_busy_q;
    tx_done_d  = 1'b0;

    if (!bus.txEn) begin
      tx_state_d = TX_IDLE;
      tx_cnt_d   = '0;
      tx_bit_d   = '0;
      tx_d       = 1'b1;
      tx_busy_d  = 1'b0;
    end else begin
      unique case (tx_state_q)
        TX_IDLE: begin
          if (bus.txStart) begin
            tx_shift_d = bus.in;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_d       = 1'b0;
            tx_busy_d  = 1'b1;
            tx_state_d = TX_START;
          end
        end
        TX_START: begin
          tx_cnt_d = tx_cnt_q + c_TXD_W'(1);
          if (w_tx_last) begin
            tx_cnt_d   = '0;
            tx_d       = tx_shift_q[0];
            tx_state_d = TX_DATA;
          end
        end
        TX_DATA: begin
          tx_cnt_d = tx_cnt_q + c_TXD_W'(1);
          if (w_tx_last) begin
            tx_cnt_d = '0;
            tx_bit_d = tx_bit_q + 3'd1;
            if (tx_bit_q == 3'd7) begin
              tx_d       = 1'b1;
              tx_state_d = TX_STOP;
            end else begin
              tx_shift_d = {1'b0, tx_shift_q[7:1]};
              tx_d       = tx_shift_q[1];
            end
          end
        end
        TX_STOP: begin
          // txDone is registered, so raise it one clock early to land on the final stop clock.
          tx_cnt_d  = tx_cnt_q + c_TXD_W'(1);
          tx_done_d = (tx_cnt_q == c_TXD_W'(c_TX_DIV - 2));
          if (w_tx_last) begin
            tx_cnt_d = '0;
            tx_bit_d = '0;
            if (bus.txStart) begin
              tx_shift_d = bus.in;
              tx_d       = 1'b0;
              tx_state_d = TX_START;
            end else begin
              tx_d       = 1'b1;
              tx_busy_d  = 1'b0;
              tx_state_d = TX_IDLE;
            end
          end
        end
        default: begin
          tx_state_d = TX_IDLE;
          tx_d       = 1'b1;
          tx_busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign bus.tx     = tx_q;
  assign bus.txBusy = tx_busy_q;
  assign bus.txDone = tx_done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart8.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart8 : randomized frames against a bit-list reference model of uart8    |
// | Rev 1.0  : initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_uart8;
  localparam int CLK_HZ   = 6400000;
  localparam int BAUD     = 100000;
  localparam int BIT_CLKS = CLK_HZ / BAUD;

  logic clk = 1'b0;
  logic reset;
  uart8_if u_if ();

  uart8 #(.CLOCK_RATE(CLK_HZ), .BAUD_RATE(BAUD)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (u_if)
  );

  always #5 clk = ~clk;

  int         n_total = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         rx_done_cnt = 0;
  int         tx_done_cnt = 0;
  int         tx_done_at = 0;
  logic [7:0] rx_last_out = 8'h00;

  logic [7:0] exp_out = 8'h00;
  int         exp_done = 0;
  logic       exp_err = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (u_if.rxDone === 1'b1) begin
      rx_done_cnt++;
      rx_last_out = u_if.out;
    end
    if (u_if.txDone === 1'b1) begin
      tx_done_cnt++;
      tx_done_at = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Serial line driven as a list of ten bit levels; abort_bit >= 0 drops rxEn inside that bit.
  task automatic rx_frame(input logic [7:0] d, input int per, input bit stop_ok, input int abort_bit);
    logic [9:0] bits;
    bit         aborted;
    aborted = 1'b0;
    bits = {stop_ok, d, 1'b0};
    @(negedge clk);
    for (int b = 0; b < 10; b++) begin
      u_if.rx = bits[b];
      for (int c = 0; c < per; c++) begin
        @(negedge clk);
        if (b == abort_bit && c == per / 2) begin
          u_if.rxEn = 1'b0;
          aborted = 1'b1;
        end else if (b == abort_bit && c == per / 2 + 1) begin
          check("rxBusy after rxEn low", u_if.rxBusy, 1'b0);
        end else if (!aborted && b < 9 && c == per / 2) begin
          check("rxBusy mid bit", u_if.rxBusy, 1'b1);
          if (b == 0) check("rxErr after start", u_if.rxErr, 1'b0);
        end
      end
    end
    u_if.rx = 1'b1;
    repeat (40) @(negedge clk);
    if (aborted) begin
      u_if.rxEn = 1'b1;
      exp_err = 1'b0;
      @(negedge clk);
    end else if (stop_ok) begin
      exp_out = d;
      exp_done++;
      exp_err = 1'b0;
      check("out at rxDone", rx_last_out, d);
    end else begin
      exp_err = 1'b1;
    end
    check("rxDone count", rx_done_cnt, exp_done);
    check("out", u_if.out, exp_out);
    check("rxErr", u_if.rxErr, exp_err);
    check("rxBusy idle", u_if.rxBusy, 1'b0);
  endtask

  task automatic rx_glitch();
    @(negedge clk);
    u_if.rx = 1'b0;
    repeat (8) @(negedge clk);
    check("rxBusy glitch start", u_if.rxBusy, 1'b1);
    repeat (2) @(negedge clk);
    u_if.rx = 1'b1;
    repeat (60) @(negedge clk);
    check("rxBusy after glitch", u_if.rxBusy, 1'b0);
    check("rxErr after glitch", u_if.rxErr, 1'b0);
    check("rxDone after glitch", rx_done_cnt, exp_done);
  endtask

  // Expected line: start 0, data LSB first, stop 1, each BIT_CLKS long from the clock after acceptance.
  task automatic tx_frame(input logic [7:0] d, input bit hold);
    logic [9:0] bits;
    int         t0;
    int         done0;
    bits  = {1'b1, d, 1'b0};
    done0 = tx_done_cnt;
    @(negedge clk);
    u_if.in      = d;
    u_if.txStart = 1'b1;
    @(negedge clk);
    t0 = cyc;
    if (!hold) u_if.txStart = 1'b0;
    check("txBusy accepted", u_if.txBusy, 1'b1);
    for (int k = 0; k < 10 * BIT_CLKS; k++) begin
      if (k > 0) @(negedge clk);
      if (k % BIT_CLKS == 0 || k % BIT_CLKS == BIT_CLKS - 1)
        check($sformatf("tx bit %0d", k / BIT_CLKS), u_if.tx, bits[k / BIT_CLKS]);
      if (k % BIT_CLKS == BIT_CLKS / 2)
        check("txBusy mid frame", u_if.txBusy, 1'b1);
    end
    @(negedge clk);
    if (hold) begin
      check("tx back-to-back start", u_if.tx, 1'b0);
      check("txBusy back-to-back", u_if.txBusy, 1'b1);
      u_if.txStart = 1'b0;
      repeat (10 * BIT_CLKS + 5) @(negedge clk);
      check("txDone count held", tx_done_cnt, done0 + 2);
      check("txDone cycle held", tx_done_at - t0, 20 * BIT_CLKS - 1);
    end else begin
      check("txBusy after frame", u_if.txBusy, 1'b0);
      check("tx idle after frame", u_if.tx, 1'b1);
      repeat (3) @(negedge clk);
      check("txDone count", tx_done_cnt, done0 + 1);
      check("txDone cycle", tx_done_at - t0, 10 * BIT_CLKS - 1);
    end
  endtask

  task automatic tx_abort();
    int done0;
    done0 = tx_done_cnt;
    @(negedge clk);
    u_if.in      = 8'h00;
    u_if.txStart = 1'b1;
    @(negedge clk);
    u_if.txStart = 1'b0;
    repeat (200) @(negedge clk);
    u_if.txEn = 1'b0;
    @(negedge clk);
    check("tx after txEn low", u_if.tx, 1'b1);
    check("txBusy after txEn low", u_if.txBusy, 1'b0);
    repeat (10 * BIT_CLKS) @(negedge clk);
    check("no txDone after abort", tx_done_cnt, done0);
    u_if.txEn = 1'b1;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: run did not finish, total=%0d", n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    u_if.rx      = 1'b1;
    u_if.rxEn    = 1'b1;
    u_if.txEn    = 1'b1;
    u_if.txStart = 1'b0;
    u_if.in      = 8'h00;
    reset        = 1'b1;
    repeat (5) @(negedge clk);
    check("reset rxBusy", u_if.rxBusy, 1'b0);
    check("reset rxDone", u_if.rxDone, 1'b0);
    check("reset rxErr", u_if.rxErr, 1'b0);
    check("reset out", u_if.out, 8'h00);
    check("reset tx", u_if.tx, 1'b1);
    check("reset txBusy", u_if.txBusy, 1'b0);
    check("reset txDone", u_if.txDone, 1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    rx_frame(8'hD6, BIT_CLKS + 2, 1'b1, -1);
    rx_glitch();
    rx_frame(8'h3C, BIT_CLKS, 1'b0, -1);
    rx_frame(8'($urandom), BIT_CLKS - 1, 1'b1, -1);
    rx_frame(8'($urandom), BIT_CLKS, 1'b1, 3);
    rx_frame(8'h5A, BIT_CLKS, 1'b1, -1);
    for (int i = 0; i < 6; i++)
      rx_frame(8'($urandom), int'($urandom_range(BIT_CLKS - 2, BIT_CLKS + 2)), 1'b1, -1);

    tx_frame(8'hA5, 1'b0);
    for (int i = 0; i < 4; i++) tx_frame(8'($urandom), 1'b0);
    tx_frame(8'($urandom), 1'b1);
    tx_abort();

    for (int i = 0; i < 2; i++) begin
      fork
        rx_frame(8'($urandom), int'($urandom_range(BIT_CLKS - 2, BIT_CLKS + 2)), 1'b1, -1);
        tx_frame(8'($urandom), 1'b0);
      join
    end

    // Reset with both engines mid-frame.
    @(negedge clk);
    u_if.in      = 8'hFF;
    u_if.txStart = 1'b1;
    @(negedge clk);
    u_if.txStart = 1'b0;
    u_if.rx      = 1'b0;
    repeat (100) @(negedge clk);
    check("rxBusy before reset", u_if.rxBusy, 1'b1);
    check("txBusy before reset", u_if.txBusy, 1'b1);
    reset   = 1'b1;
    u_if.rx = 1'b1;
    @(negedge clk);
    check("midreset rxBusy", u_if.rxBusy, 1'b0);
    check("midreset rxDone", u_if.rxDone, 1'b0);
    check("midreset rxErr", u_if.rxErr, 1'b0);
    check("midreset out", u_if.out, 8'h00);
    check("midreset tx", u_if.tx, 1'b1);
    check("midreset txBusy", u_if.txBusy, 1'b0);
    check("midreset txDone", u_if.txDone, 1'b0);
    reset   = 1'b0;
    exp_out = 8'h00;
    exp_err = 1'b0;
    repeat (5) @(negedge clk);

    rx_frame(8'($urandom), BIT_CLKS, 1'b1, -1);
    tx_frame(8'($urandom), 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
